// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    // Fetch sequencer states: issue request, await data, present to decoder.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 -- what the decoder sees whenever nothing is valid.
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction fetch is word-granular; low two bits never reach memory.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: reset value, redirect load, sequential increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_target,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;

    // Load beats increment so a redirect always wins over the sequential path.
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= word_align(RESET_PC);
        else if (i_load)
            r_pc <= word_align(i_target);
        else if (i_inc)
            r_pc <= r_pc + 32'd4;
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + 32'd4;   // wraps modulo 2^32

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, one held
// instruction, redirects from the decoder squash in-flight or held work.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i
);

    fetch_state_t state_q;
    logic [31:0]  instr_q;
    logic         kill_q;

    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_pc_inc;
    logic         w_in_hold;

    assign w_in_hold = (state_q == S_HOLD);

    // Sequential advance only when the decoder consumes without branching.
    assign w_pc_inc = w_in_hold & instr_ready_i & ~redirect_i;

    pc_reg #(
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (redirect_i),
        .i_target   (redirect_target_i),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // Fetch sequencer; kill_q marks a granted request whose data must be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            kill_q  <= 1'b0;
            instr_q <= INSTR_NOP;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_q <= S_WAIT;
                        kill_q  <= redirect_i;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (!kill_q && !redirect_i) begin
                            instr_q <= imem_rdata_i;
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i || redirect_i)
                        state_q <= S_REQ;
                end
                default: begin
                    state_q <= S_REQ;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; reset masks them at once
    // so a mid-operation reset never shows a stale request or instruction.
    assign imem_req_o    = (state_q == S_REQ) & ~rst;
    assign imem_addr_o   = w_pc;
    assign instr_valid_o = w_in_hold & ~rst;
    assign instr_o       = (w_in_hold & ~rst) ? instr_q : INSTR_NOP;
    assign pc_o          = rst ? word_align(RESET_PC) : w_pc;
    assign pc_plus4_o    = rst ? word_align(RESET_PC) + 32'd4 : w_pc_plus4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RISC-V core: owns the PC register, issues word requests to instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to the decoder (`control_unit`) with a valid/ready handshake. Consumes the decoder's branch decision (`PCSrc`) and target as a redirect, making it the producer end of the decoder's instruction interface and the consumer of its PC-select output.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  word-aligned fetch address.
- `imem_gnt_i`  in  1  memory accepts request this cycle.
- `imem_rvalid_i`  in  1  read data valid; earliest one cycle after gnt; at most one per gnt.
- `imem_rdata_i`  in  32  instruction word.
- `instr_o`  out  32  instruction to decoder; 32'h0000_0013 (NOP) when not valid.
- `pc_o`  out  32  PC of `instr_o`.
- `pc_plus4_o`  out  32  `pc_o` + 4.
- `instr_valid_o`  out  1  `instr_o` is valid.
- `instr_ready_i`  in  1  decoder/execute consumes instruction this cycle.
- `redirect_i`  in  1  take branch (decoder `PCSrc`) or external flush.
- `redirect_target_i`  in  32  new PC; bits [1:0] ignored (forced 0).

## Operation
- Registers: `pc_q`, `instr_q`, `kill_q`, `state_q`. At most one outstanding memory request.
- States: S_REQ, S_WAIT, S_HOLD.
- S_REQ: `imem_req_o`=1, `imem_addr_o`=`pc_q`.
  - gnt & ~redirect -> S_WAIT.
  - gnt & redirect -> S_WAIT, `kill_q`<=1, `pc_q`<=target.
  - ~gnt & redirect -> stay, `pc_q`<=target (address changes next cycle; the only legal address change while req is held).
- S_WAIT: `imem_req_o`=0.
  - rvalid & ~kill_q & ~redirect -> `instr_q`<=rdata, S_HOLD.
  - rvalid & (kill_q | redirect) -> drop data, `kill_q`<=0, S_REQ; if redirect, `pc_q`<=target.
  - ~rvalid & redirect -> `kill_q`<=1, `pc_q`<=target, stay.
- S_HOLD: `instr_valid_o`=1, `instr_o`=`instr_q`, `pc_o`=`pc_q`.
  - ready & redirect -> `pc_q`<=target, S_REQ (taken branch).
  - ready & ~redirect -> `pc_q`<=`pc_q`+4, S_REQ.
  - ~ready & redirect -> instruction flushed, `pc_q`<=target, S_REQ.
  - ~ready & ~redirect -> hold all outputs stable.
- Redirect has priority over sequential increment in every state; the last redirect before a request issues wins.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0. `pc_plus4_o` uses the same wrap.
- Outside S_HOLD: `instr_valid_o`=0, `instr_o`=NOP, `pc_o`=`pc_q`.

## Timing
- Reset: while `rst`=1, `imem_req_o`=0, `instr_valid_o`=0, `instr_o`=NOP, `pc_o`=`RESET_PC`, `kill_q`=0; state set to S_REQ. First request in the first cycle after `rst` falls.
- `rst` mid-operation: in-flight request abandoned; any rvalid arriving later is ignored (state S_REQ, not S_WAIT).
- Throughput with 1-cycle memory and ready always high: one instruction per 3 cycles (req/gnt, rvalid, hold/consume).
- `instr_valid_o` rises the cycle after rvalid; outputs are registered, none combinational from memory inputs.
- `redirect_i` and `instr_ready_i` are used combinationally only for next-state; no output depends on them in the same cycle except none.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (S_REQ, S_WAIT, S_HOLD), `INSTR_NOP` = 32'h0000_0013, `RESET_PC_DEFAULT`.
- Sub-module `pc_reg`: holds `pc_q`, inputs load-enable/target and increment-enable; outputs `pc_q` and `pc_q`+4 with target alignment masking.

## Test plan
- Reset release, 1-cycle memory returning 32'h0000_0093 at 0, 32'h0010_0113 at 4 -> req addr 0 first cycle after reset, valid on cycle 2 with pc 0, next req addr 4 on cycle 3.
- Stall: `instr_ready_i`=0 for 5 cycles in S_HOLD -> `instr_o`/`pc_o` stable, no request, advances to pc+4 when ready rises.
- Taken branch: accept instruction at pc 0x10 with redirect=1, target 0x40 -> next request address 0x40, pc_o 0x40 on next valid.
- Redirect while in S_WAIT (target 0x80), memory returns stale word -> word dropped, never valid; next request address 0x80.
- gnt delayed 3 cycles with redirect to 0x23 in cycle 2 -> address changes to 0x20, held until gnt.
- Wrap: `RESET_PC`=32'hFFFF_FFFC -> first valid pc 0xFFFF_FFFC, `pc_plus4_o`=0, second request address 0.
